// File: rtl/display_scan_decoder_if.sv
// ============================================================================
// Module      : display_scan_decoder_if
// Description : Bus between the timer/control side and the display scan
//               decoder. Carries the three BCD digits and the status flags
//               toward the decoder, and the 7-segment drive back out.
//   minutes       4  BCD minutes digit
//   seconds_tens  4  BCD tens-of-seconds digit
//   seconds_ones  4  BCD ones-of-seconds digit
//   mag_on        1  magnetron running (cooking)
//   timer_done    1  countdown reached zero
//   seg           7  segments {g,f,e,d,c,b,a}, active-low
//   an            3  digit enables, active-low (0=ones,1=tens,2=minutes)
//   colon         1  colon LED, active-high
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface display_scan_decoder_if;
    logic [3:0] minutes;
    logic [3:0] seconds_tens;
    logic [3:0] seconds_ones;
    logic       mag_on;
    logic       timer_done;
    logic [6:0] seg;
    logic [2:0] an;
    logic       colon;

    // Timer/control side: supplies digits and flags, observes display drive.
    modport master (
        output minutes, seconds_tens, seconds_ones, mag_on, timer_done,
        input  seg, an, colon
    );

    // Decoder side.
    modport slave (
        input  minutes, seconds_tens, seconds_ones, mag_on, timer_done,
        output seg, an, colon
    );
endinterface

`default_nettype wire

// File: rtl/display_scan_decoder.sv
// ============================================================================
// Module      : display_scan_decoder
// Description : Time-multiplexed driver for a three-digit common-anode
//               7-segment display. Snapshots the timer digits once per scan
//               frame, applies leading-zero blanking, blinks the colon while
//               cooking and flashes the whole display when the timer is done.
// Ports       :
//   clk    in   system clock
//   clear  in   synchronous reset, active-high
//   bus    slave modport of display_scan_decoder_if (digits, flags, drive)
// Parameters  :
//   SCAN_DIV      clk cycles each digit is driven (>= 2)
//   BLINK_FRAMES  scan frames per blink half-period (>= 1)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan_decoder #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 50
) (
    input  wire logic              clk,
    input  wire logic              clear,
    display_scan_decoder_if.slave  bus
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        DIG_ONES = 2'd0,
        DIG_TENS = 2'd1,
        DIG_MIN  = 2'd2
    } digit_t;

    logic [SCAN_W-1:0]  scan_cnt_q;
    digit_t             digit_sel_q;
    logic [FRAME_W-1:0] frame_cnt_q;
    logic               blink_phase_q;
    logic [3:0]         snap_min_q;
    logic [3:0]         snap_tens_q;
    logic [3:0]         snap_ones_q;
    logic [6:0]         seg_q;
    logic [2:0]         an_q;
    logic               colon_q;

    logic               scan_wrap;
    logic               frame_end;
    digit_t             digit_sel_d;
    logic [3:0]         digit_val;
    logic               digit_blank;
    logic [2:0]         an_d;
    logic [6:0]         seg_d;
    logic               dark;

    // BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    always_comb begin
        scan_wrap = (scan_cnt_q == SCAN_LAST);
        frame_end = scan_wrap && (digit_sel_q == DIG_MIN);

        digit_sel_d = digit_sel_q;
        case (digit_sel_q)
            DIG_ONES: digit_sel_d = DIG_TENS;
            DIG_TENS: digit_sel_d = DIG_MIN;
            default:  digit_sel_d = DIG_ONES;
        endcase

        // Blanking tests the snapshot for zero, so a dash (10..15) is
        // never suppressed.
        digit_val   = snap_ones_q;
        digit_blank = 1'b0;
        an_d        = 3'b111;
        case (digit_sel_q)
            DIG_ONES: begin
                digit_val   = snap_ones_q;
                digit_blank = 1'b0;
                an_d        = 3'b110;
            end
            DIG_TENS: begin
                digit_val   = snap_tens_q;
                digit_blank = (snap_min_q == 4'd0) && (snap_tens_q == 4'd0);
                an_d        = 3'b101;
            end
            DIG_MIN: begin
                digit_val   = snap_min_q;
                digit_blank = (snap_min_q == 4'd0);
                an_d        = 3'b011;
            end
            default: begin
                digit_val   = 4'd0;
                digit_blank = 1'b1;
                an_d        = 3'b111;
            end
        endcase

        seg_d = digit_blank ? SEG_BLANK : bcd_to_seg(digit_val);
        dark  = bus.timer_done && blink_phase_q;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            scan_cnt_q    <= '0;
            digit_sel_q   <= DIG_ONES;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            snap_min_q    <= 4'd0;
            snap_tens_q   <= 4'd0;
            snap_ones_q   <= 4'd0;
            seg_q         <= SEG_BLANK;
            an_q          <= 3'b111;
            colon_q       <= 1'b0;
        end else begin
            scan_cnt_q <= scan_wrap ? '0 : scan_cnt_q + 1'b1;
            if (scan_wrap) begin
                digit_sel_q <= digit_sel_d;
            end

            // Latching on the last cycle of the frame keeps all three digits
            // of the next frame coherent; the blink update shares this edge.
            if (frame_end) begin
                snap_min_q  <= bus.minutes;
                snap_tens_q <= bus.seconds_tens;
                snap_ones_q <= bus.seconds_ones;
                if (frame_cnt_q == FRAME_LAST) begin
                    frame_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                end
            end

            // seg and an update on the same edge so no digit shows the
            // neighbour's pattern.
            seg_q   <= seg_d;
            an_q    <= dark ? 3'b111 : an_d;
            colon_q <= (bus.timer_done || bus.mag_on) ? ~blink_phase_q : 1'b1;
        end
    end

    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.colon = colon_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_decoder.sv
// ============================================================================
// Module      : tb_display_scan_decoder
// Description : Self-checking bench for display_scan_decoder. A reference
//               model derives the expected display from the elapsed cycle
//               count since reset and a per-frame snapshot of the inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_scan_decoder;

    localparam int SD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = 3 * SD;

    logic clk;
    logic clear;

    display_scan_decoder_if bus ();

    display_scan_decoder #(
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                 7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h3F,
                                 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    int         n_checks = 0;
    int         n_fail   = 0;
    int         k        = 0;   // edges since reset release
    logic [3:0] m_min    = 4'd0;
    logic [3:0] m_tens   = 4'd0;
    logic [3:0] m_ones   = 4'd0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)",
                     tag, got, exp, k, $time);
        end
    endtask

    // One clock edge: predict outputs from model state, then compare.
    task automatic tick();
        logic [6:0] es;
        logic [2:0] ea;
        logic       ec;
        logic [3:0] v;
        bit         blank;
        int         dig;
        int         ph;
        @(posedge clk);
        if (clear) begin
            es = 7'h7F; ea = 3'b111; ec = 1'b0;
            k = 0; m_min = 4'd0; m_tens = 4'd0; m_ones = 4'd0;
        end else begin
            dig = (k / SD) % 3;
            ph  = ((k / FRAME) / BF) % 2;
            case (dig)
                0:       begin v = m_ones; blank = 1'b0;                      ea = 3'b110; end
                1:       begin v = m_tens; blank = (m_min == 0 && m_tens == 0); ea = 3'b101; end
                default: begin v = m_min;  blank = (m_min == 0);               ea = 3'b011; end
            endcase
            es = blank ? 7'h7F : seg_tab[v];
            if (bus.timer_done && ph == 1) ea = 3'b111;
            ec = (bus.timer_done || bus.mag_on) ? (ph == 0) : 1'b1;
            if (k % FRAME == FRAME - 1) begin
                m_min  = bus.minutes;
                m_tens = bus.seconds_tens;
                m_ones = bus.seconds_ones;
            end
            k++;
        end
        #1;
        check_val("seg", 32'(bus.seg), 32'(es));
        check_val("an", 32'(bus.an), 32'(ea));
        check_val("colon", 32'(bus.colon), 32'(ec));
        check_val("an_onehot", 32'(bus.an inside {3'b110, 3'b101, 3'b011, 3'b111}), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_digits(input logic [3:0] mn, input logic [3:0] tn,
                              input logic [3:0] on);
        bus.minutes      = mn;
        bus.seconds_tens = tn;
        bus.seconds_ones = on;
    endtask

    // Advance until the next edge will be the first one with digit_sel==d.
    task automatic run_to_digit(input int d);
        for (int i = 0; i < FRAME + 1; i++) begin
            if ((k / SD) % 3 == d && k % SD == 0) break;
            tick();
        end
    endtask

    initial begin
        clear          = 1'b1;
        bus.mag_on     = 1'b0;
        bus.timer_done = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0);

        // Reset held, then release into an all-zero first frame.
        run(3);
        clear = 1'b0;
        run(FRAME);

        // Normal digits, colon steady.
        set_digits(4'd2, 4'd3, 4'd7);
        run(2 * FRAME);

        // Leading-zero blanking.
        set_digits(4'd0, 4'd0, 4'd5);
        run(2 * FRAME);
        set_digits(4'd0, 4'd4, 4'd0);
        run(2 * FRAME);

        // Mid-frame change is deferred to the following frame.
        set_digits(4'd0, 4'd0, 4'd1);
        run_to_digit(0);
        run(FRAME);
        run_to_digit(1);
        set_digits(4'd0, 4'd0, 4'd9);
        run(2 * FRAME);

        // Cooking colon blink, then done flash.
        bus.mag_on = 1'b1;
        run(8 * FRAME);
        bus.timer_done = 1'b1;
        run(8 * FRAME);
        bus.timer_done = 1'b0;
        bus.mag_on     = 1'b0;

        // Dash on an invalid digit, then reset while driving minutes.
        set_digits(4'd1, 4'd0, 4'd12);
        run(2 * FRAME);
        run_to_digit(2);
        run(1);
        clear = 1'b1;
        run(1);
        clear = 1'b0;
        run(FRAME);

        // Randomized traffic with occasional resets.
        for (int it = 0; it < 60; it++) begin
            set_digits(4'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 15)),
                       4'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 15)),
                       4'($urandom_range(0, 15)));
            bus.mag_on     = 1'($urandom_range(0, 1));
            bus.timer_done = 1'($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 14) == 0) begin
                clear = 1'b1;
                run(int'($urandom_range(1, 2)));
                clear = 1'b0;
            end
            run(int'($urandom_range(1, 40)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
